// File: rtl/avm_arb_pkg.sv
// Shared types and constants for the two-requester Avalon-MM round-robin arbiter.
package avm_arb_pkg;

   typedef enum logic {
      OWNER_S0 = 1'b0,
      OWNER_S1 = 1'b1
   } owner_t;

   // Requester IDs as stored in the read tag FIFO
   localparam logic PORT_S0 = 1'b0;
   localparam logic PORT_S1 = 1'b1;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned v;
      int unsigned r;
      v = (value > 0) ? value - 1 : 0;
      r = 0;
      while (v > 0) begin
         v = v >> 1;
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/avm_rd_tag_fifo.sv
// In-order FIFO of 1-bit requester tags; one entry per read still awaiting its response.
module avm_rd_tag_fifo #(
   parameter int DEPTH = 64,
   parameter int AW    = 6
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        push_i,
   input  logic        data_i,
   input  logic        pop_i,
   output logic        full_o,
   output logic        empty_o,
   output logic        head_o,
   output logic [AW:0] count_o
);

   localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

   logic          mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          do_push, do_pop;

   assign full_o  = (count_q == FULL_COUNT);
   assign empty_o = (count_q == '0);
   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + (AW + 1)'(1);
         2'b01:   count_d = count_q - (AW + 1)'(1);
         default: count_d = count_q;
      endcase
   end

   // NOTE: registers use non-blocking assignments so every flop samples the pre-edge value of every other flop.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: tag storage is deliberately not reset; an entry is only read after the pointers say it was written.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/avm_rr_arbiter.sv
// Round-robin, owner-parked arbiter sharing one Avalon-MM master between two requesters,
// with read responses steered back by an in-order tag FIFO.
module avm_rr_arbiter
   import avm_arb_pkg::*;
#(
   parameter int AVM_WIDTH        = 512,
   parameter int AVM_ADDR_WIDTH   = 64,
   parameter int AVM_BYTEEN_WIDTH = 64,
   parameter int RD_TAG_DEPTH     = 64,
   parameter int RD_TAG_AW        = clog2(RD_TAG_DEPTH)
) (
   input  logic                        clk,
   input  logic                        reset,
   output logic                        s0_waitrequest,
   output logic [AVM_WIDTH-1:0]        s0_readdata,
   output logic                        s0_readdatavalid,
   input  logic [AVM_WIDTH-1:0]        s0_writedata,
   input  logic [AVM_ADDR_WIDTH-1:0]   s0_address,
   input  logic                        s0_write,
   input  logic                        s0_read,
   input  logic [AVM_BYTEEN_WIDTH-1:0] s0_byteenable,
   output logic                        s1_waitrequest,
   output logic [AVM_WIDTH-1:0]        s1_readdata,
   output logic                        s1_readdatavalid,
   input  logic [AVM_WIDTH-1:0]        s1_writedata,
   input  logic [AVM_ADDR_WIDTH-1:0]   s1_address,
   input  logic                        s1_write,
   input  logic                        s1_read,
   input  logic [AVM_BYTEEN_WIDTH-1:0] s1_byteenable,
   input  logic                        m0_waitrequest,
   input  logic [AVM_WIDTH-1:0]        m0_readdata,
   input  logic                        m0_readdatavalid,
   output logic [AVM_WIDTH-1:0]        m0_writedata,
   output logic [AVM_ADDR_WIDTH-1:0]   m0_address,
   output logic                        m0_write,
   output logic                        m0_read,
   output logic [AVM_BYTEEN_WIDTH-1:0] m0_byteenable,
   output logic [RD_TAG_AW:0]          rd_outstanding,
   output logic                        rsp_error
);

   owner_t             state_q, state_d;
   logic               rsp_error_q, rsp_error_d;
   logic               own_s1;
   logic               req_s0, req_s1, req_owner, req_other;
   logic               owner_read, owner_write, owner_wait, accept;
   logic               fifo_full, fifo_empty, fifo_head;
   logic [RD_TAG_AW:0] fifo_count;

   assign req_s0      = s0_read | s0_write;
   assign req_s1      = s1_read | s1_write;
   assign own_s1      = (state_q == OWNER_S1);
   assign req_owner   = own_s1 ? req_s1 : req_s0;
   assign req_other   = own_s1 ? req_s0 : req_s1;
   assign owner_read  = own_s1 ? s1_read  : s0_read;
   assign owner_write = own_s1 ? s1_write : s0_write;

   // Only reads back-pressure on a full tag FIFO; writes need no tag
   assign owner_wait = m0_waitrequest | (owner_read & fifo_full);
   assign accept     = ~reset & req_owner & ~owner_wait;

   assign m0_address    = own_s1 ? s1_address    : s0_address;
   assign m0_writedata  = own_s1 ? s1_writedata  : s0_writedata;
   assign m0_byteenable = own_s1 ? s1_byteenable : s0_byteenable;
   assign m0_write      = ~reset & owner_write;
   assign m0_read       = ~reset & owner_read & ~fifo_full;

   assign s0_waitrequest = reset | own_s1  | owner_wait;
   assign s1_waitrequest = reset | ~own_s1 | owner_wait;

   // Hand over after the owner is served, or when it is idle; never while it is stalled
   always_comb begin
      state_d = state_q;
      if (req_other & (accept | ~req_owner)) begin
         state_d = own_s1 ? OWNER_S0 : OWNER_S1;
      end
   end

   assign rsp_error_d = rsp_error_q | (m0_readdatavalid & fifo_empty);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= OWNER_S0;
         rsp_error_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rsp_error_q <= rsp_error_d;
      end
   end

   avm_rd_tag_fifo #(
      .DEPTH (RD_TAG_DEPTH),
      .AW    (RD_TAG_AW)
   ) u_rd_tag_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (accept & owner_read),
      .data_i  (own_s1 ? PORT_S1 : PORT_S0),
      .pop_i   (~reset & m0_readdatavalid),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .head_o  (fifo_head),
      .count_o (fifo_count)
   );

   assign s0_readdata      = m0_readdata;
   assign s1_readdata      = m0_readdata;
   assign s0_readdatavalid = ~reset & m0_readdatavalid & ~fifo_empty & (fifo_head == PORT_S0);
   assign s1_readdatavalid = ~reset & m0_readdatavalid & ~fifo_empty & (fifo_head == PORT_S1);

   assign rd_outstanding = fifo_count;
   assign rsp_error      = rsp_error_q;

endmodule

// File: tb/tb_avm_rr_arbiter.sv
// Scoreboard bench for avm_rr_arbiter: directed scenarios followed by randomized traffic,
// checked against a queue-based arbitration and read-ownership model.
module tb_avm_rr_arbiter;

   localparam int DW    = 32;
   localparam int AW    = 32;
   localparam int BW    = 4;
   localparam int DEPTH = 4;
   localparam int TAW   = 2;

   typedef struct {
      bit            rd;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [BW-1:0] be;
   } cmd_t;

   typedef struct {
      int            port;
      logic [DW-1:0] data;
   } rsp_t;

   logic          clk = 1'b0;
   logic          reset;
   logic [1:0]    s_rd = '0;
   logic [1:0]    s_wr = '0;
   logic [1:0]    s_wait, s_rdv;
   logic [DW-1:0] s_wd [2];
   logic [DW-1:0] s_rdata [2];
   logic [AW-1:0] s_addr [2];
   logic [BW-1:0] s_be [2];
   logic          m0_wait, m0_rdv, m0_write, m0_read;
   logic [DW-1:0] m0_rdata, m0_wd;
   logic [AW-1:0] m0_addr;
   logic [BW-1:0] m0_be;
   logic [TAW:0]  rd_outstanding;
   logic          rsp_error;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   avm_rr_arbiter #(
      .AVM_WIDTH        (DW),
      .AVM_ADDR_WIDTH   (AW),
      .AVM_BYTEEN_WIDTH (BW),
      .RD_TAG_DEPTH     (DEPTH),
      .RD_TAG_AW        (TAW)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .s0_waitrequest   (s_wait[0]),
      .s0_readdata      (s_rdata[0]),
      .s0_readdatavalid (s_rdv[0]),
      .s0_writedata     (s_wd[0]),
      .s0_address       (s_addr[0]),
      .s0_write         (s_wr[0]),
      .s0_read          (s_rd[0]),
      .s0_byteenable    (s_be[0]),
      .s1_waitrequest   (s_wait[1]),
      .s1_readdata      (s_rdata[1]),
      .s1_readdatavalid (s_rdv[1]),
      .s1_writedata     (s_wd[1]),
      .s1_address       (s_addr[1]),
      .s1_write         (s_wr[1]),
      .s1_read          (s_rd[1]),
      .s1_byteenable    (s_be[1]),
      .m0_waitrequest   (m0_wait),
      .m0_readdata      (m0_rdata),
      .m0_readdatavalid (m0_rdv),
      .m0_writedata     (m0_wd),
      .m0_address       (m0_addr),
      .m0_write         (m0_write),
      .m0_read          (m0_read),
      .m0_byteenable    (m0_be),
      .rd_outstanding   (rd_outstanding),
      .rsp_error        (rsp_error)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- requester drivers: hold each command until accepted ----------------
   cmd_t s_q [2][$];
   bit   acc_seen [2];

   always @(negedge clk) begin
      for (int p = 0; p < 2; p++) acc_seen[p] = (s_rd[p] | s_wr[p]) & ~s_wait[p];
   end

   always @(posedge clk) begin
      #2;
      for (int p = 0; p < 2; p++) begin
         if (acc_seen[p] && s_q[p].size() > 0) s_q[p].delete(0);
         if (s_q[p].size() > 0) begin
            s_rd[p]   = s_q[p][0].rd;
            s_wr[p]   = !s_q[p][0].rd;
            s_addr[p] = s_q[p][0].addr;
            s_wd[p]   = s_q[p][0].data;
            s_be[p]   = s_q[p][0].be;
         end else begin
            s_rd[p]   = 1'b0;
            s_wr[p]   = 1'b0;
            s_addr[p] = '0;
            s_wd[p]   = '0;
            s_be[p]   = '0;
         end
      end
   end

   // ---------------- reference model: owner token, tag queue, sticky error ----------------
   int   m_owner = 0;
   bit   m_err   = 1'b0;
   int   m_tags[$];
   cmd_t exp_cmd_q[$];
   rsp_t exp_rsp_q[$];

   always @(negedge clk) begin
      bit [1:0]   req;
      logic [1:0] exp_wait;
      int         own, oth;
      bit         full, stall;
      rsp_t       r;
      cmd_t       c;
      req = s_rd | s_wr;
      check("rd_outstanding", rd_outstanding, m_tags.size());
      check("rsp_error", rsp_error, m_err);
      if (reset) begin
         check("reset_outputs", {s_wait, s_rdv, m0_read, m0_write}, 6'b110000);
         m_owner = 0;
         m_err   = 1'b0;
         m_tags.delete();
      end else begin
         own   = m_owner;
         oth   = 1 - own;
         full  = (m_tags.size() == DEPTH);
         stall = m0_wait || (s_rd[own] && full);
         exp_wait      = 2'b11;
         exp_wait[own] = stall;
         check("waitrequest", s_wait, exp_wait);
         check("m0_read", m0_read, s_rd[own] && !full);
         check("m0_write", m0_write, s_wr[own]);
         if (m0_rdv) begin
            if (m_tags.size() == 0) m_err = 1'b1;
            else begin
               r.port = m_tags.pop_front();
               r.data = m0_rdata;
               exp_rsp_q.push_back(r);
            end
         end
         if (req[own] && !stall) begin
            c.rd   = s_rd[own];
            c.addr = s_addr[own];
            c.data = s_wd[own];
            c.be   = s_be[own];
            exp_cmd_q.push_back(c);
            if (s_rd[own]) m_tags.push_back(own);
         end
         if (req[oth] && (!req[own] || !stall)) m_owner = oth;
      end
   end

   // ---------------- monitor: pops expectations whenever the DUT presents output ----------------
   int            rd_issued = 0;
   int            cyc_n = 0;
   int            fire_cyc[$];
   int            fire_port[$];
   logic [DW-1:0] rx_q [2][$];
   bit            prev_stall = 1'b0;
   logic [AW-1:0] prev_addr;
   logic [DW-1:0] prev_wd;
   logic [1:0]    prev_cmd;

   always @(negedge clk) begin
      cmd_t e;
      rsp_t r;
      #1;
      cyc_n++;
      if (!reset && prev_stall) begin
         check("m0_hold_cmd", {m0_read, m0_write}, prev_cmd);
         check("m0_hold_addr", m0_addr, prev_addr);
         check("m0_hold_wdata", m0_wd, prev_wd);
      end
      if (!reset && (m0_read || m0_write) && !m0_wait) begin
         check("m0_cmd_expected", exp_cmd_q.size() > 0, 1);
         if (exp_cmd_q.size() > 0) begin
            e = exp_cmd_q.pop_front();
            check("m0_is_read", m0_read, e.rd);
            check("m0_addr", m0_addr, e.addr);
            check("m0_be", m0_be, e.be);
            if (!e.rd) check("m0_wdata", m0_wd, e.data);
         end
         fire_cyc.push_back(cyc_n);
         fire_port.push_back((!s_wait[1] && (s_rd[1] || s_wr[1])) ? 1 : 0);
         if (m0_read) rd_issued++;
      end
      for (int p = 0; p < 2; p++) begin
         if (s_rdv[p]) begin
            check("rsp_expected", exp_rsp_q.size() > 0, 1);
            if (exp_rsp_q.size() > 0) begin
               r = exp_rsp_q.pop_front();
               check("rsp_port", p, r.port);
               check("rsp_data", s_rdata[p], r.data);
            end
            rx_q[p].push_back(s_rdata[p]);
         end
      end
      prev_stall = !reset && (m0_read || m0_write) && m0_wait;
      prev_cmd   = {m0_read, m0_write};
      prev_addr  = m0_addr;
      prev_wd    = m0_wd;
   end

   // ---------------- stimulus ----------------
   int            rd_answered = 0;
   logic [DW-1:0] d [4];

   task automatic cyc();
      @(posedge clk);
      #1;
      m0_rdv = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) cyc();
   endtask

   task automatic enq(input int p, input bit rd, input logic [AW-1:0] a);
      cmd_t c;
      c.rd   = rd;
      c.addr = a;
      c.data = $urandom;
      c.be   = rd ? '1 : BW'($urandom);
      s_q[p].push_back(c);
   endtask

   task automatic clear_log();
      fire_cyc.delete();
      fire_port.delete();
   endtask

   initial begin
      reset    = 1'b1;
      m0_wait  = 1'b0;
      m0_rdv   = 1'b0;
      m0_rdata = '0;
      idle(3);
      reset = 1'b0;
      @(negedge clk);
      check("reset_owner_s0", s_wait, 2'b10);
      check("reset_outstanding", rd_outstanding, 0);

      // Lone requester: 8 back-to-back writes
      cyc();
      clear_log();
      for (int i = 0; i < 8; i++) enq(0, 1'b0, 32'h1000 + i * 64);
      idle(12);
      check("t1_fire_count", fire_cyc.size(), 8);
      if (fire_cyc.size() == 8) check("t1_back_to_back", fire_cyc[7] - fire_cyc[0], 7);
      foreach (fire_port[i]) check("t1_port", fire_port[i], 0);

      // Contending writers alternate
      cyc();
      clear_log();
      for (int i = 0; i < 3; i++) begin
         enq(0, 1'b0, 32'h2000 + i * 64);
         enq(1, 1'b0, 32'h3000 + i * 64);
      end
      idle(10);
      check("t2_fire_count", fire_cyc.size(), 6);
      if (fire_cyc.size() == 6) check("t2_back_to_back", fire_cyc[5] - fire_cyc[0], 5);
      foreach (fire_port[i]) check("t2_alternate", fire_port[i], i % 2);

      // Stalled owner keeps the bus; handover only after acceptance
      cyc();
      enq(0, 1'b0, 32'h4000);
      idle(5);
      clear_log();
      for (int k = 0; k < 3; k++) begin
         cyc();
         if (k == 0) begin
            m0_wait = 1'b1;
            enq(0, 1'b0, 32'h5000);
            enq(1, 1'b0, 32'h6000);
         end
         @(negedge clk);
         check("t3_stall_write", m0_write, 1);
         check("t3_stall_addr", m0_addr, 32'h5000);
         check("t3_stall_s1_wait", s_wait[1], 1);
      end
      cyc();
      m0_wait = 1'b0;
      idle(5);
      check("t3_fire_count", fire_port.size(), 2);
      if (fire_port.size() == 2) begin
         check("t3_first_s0", fire_port[0], 0);
         check("t3_then_s1", fire_port[1], 1);
      end

      // Tag FIFO full stalls the fifth read
      cyc();
      clear_log();
      for (int i = 0; i < 5; i++) enq(0, 1'b1, 32'h7000 + i * 64);
      idle(10);
      @(negedge clk);
      check("t4_outstanding_full", rd_outstanding, 4);
      check("t4_fifth_wait", s_wait[0], 1);
      check("t4_fifth_no_m0_read", m0_read, 0);
      check("t4_accepted", fire_cyc.size(), 4);
      cyc();
      m0_rdv   = 1'b1;
      m0_rdata = $urandom;
      cyc();
      @(negedge clk);
      check("t4_fifth_m0_read", m0_read, 1);
      check("t4_fifth_accept", s_wait[0], 0);
      for (int i = 0; i < 4; i++) begin
         cyc();
         m0_rdv   = 1'b1;
         m0_rdata = $urandom;
      end
      idle(3);
      check("t4_drained", rd_outstanding, 0);

      // Interleaved read ownership
      rx_q[0].delete();
      rx_q[1].delete();
      cyc(); enq(0, 1'b1, 32'h8000); idle(3);
      cyc(); enq(1, 1'b1, 32'h8040); idle(3);
      cyc(); enq(1, 1'b1, 32'h8080); idle(3);
      cyc(); enq(0, 1'b1, 32'h80c0); idle(3);
      check("t5_outstanding", rd_outstanding, 4);
      for (int i = 0; i < 4; i++) begin
         d[i] = $urandom;
         cyc();
         m0_rdv   = 1'b1;
         m0_rdata = d[i];
      end
      idle(3);
      check("t5_s0_count", rx_q[0].size(), 2);
      check("t5_s1_count", rx_q[1].size(), 2);
      if (rx_q[0].size() == 2 && rx_q[1].size() == 2) begin
         check("t5_s0_first", rx_q[0][0], d[0]);
         check("t5_s0_second", rx_q[0][1], d[3]);
         check("t5_s1_first", rx_q[1][0], d[1]);
         check("t5_s1_second", rx_q[1][1], d[2]);
      end
      check("t5_outstanding_zero", rd_outstanding, 0);

      // Orphan response, then reset recovery
      cyc();
      enq(1, 1'b0, 32'h9000);
      idle(3);
      cyc();
      m0_rdv   = 1'b1;
      m0_rdata = $urandom;
      @(negedge clk);
      check("t6_no_rdv", s_rdv, 2'b00);
      idle(3);
      @(negedge clk);
      check("t6_error_sticky", rsp_error, 1);
      cyc();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      @(negedge clk);
      check("t6_error_cleared", rsp_error, 0);
      check("t6_outstanding_cleared", rd_outstanding, 0);
      check("t6_owner_s0", s_wait, 2'b10);

      // Randomized traffic with one mid-run reset
      rd_answered = rd_issued;
      for (int n = 0; n < 1500; n++) begin
         cyc();
         reset   = (n == 700);
         m0_wait = ($urandom % 4) == 0;
         if (n == 701) rd_answered = rd_issued;
         for (int p = 0; p < 2; p++) begin
            if (s_q[p].size() < 3 && ($urandom % 3) != 0) enq(p, ($urandom % 2) == 1, $urandom);
         end
         if (!reset && n != 701 && rd_issued > rd_answered && ($urandom % 2) == 1) begin
            m0_rdv   = 1'b1;
            m0_rdata = $urandom;
            rd_answered++;
         end
      end
      m0_wait = 1'b0;
      idle(10);
      check("cmd_queue_empty", exp_cmd_q.size(), 0);
      check("rsp_queue_empty", exp_rsp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
